mac_tx_arbiter: RTL
===================

// Module: mac_tx_arbiter
// PURPOSE
//  Frame-granular round-robin arbiter sharing the single MAC transmit write port among NUM_SRC packet sources.
//  Sits between packet producers (e.g. sample packetiser, control responder) and the MAC TX interface, in the tx_clk domain.
//  Never interleaves frames. Enforces sop/eop framing and truncates over-length frames.
// PARAMETERS
//  NUM_SRC        4     number of requesters, 2..8
//  MAX_FRAME_LEN  1514  max bytes per frame excl. CRC; longer frames truncated
//  MIN_FRAME_LEN  60    pad target (TX_ARB_PAD_EN only)
// PORTS
//  tx_clk        in   1          sole clock
//  rstn          in   1          reset, asynchronous, active-low
//  src_data      in   8*NUM_SRC  byte of source i at [8i+7:8i]
//  src_sop       in   NUM_SRC    first byte of frame
//  src_eop       in   NUM_SRC    last byte of frame
//  src_valid     in   NUM_SRC    source word valid
//  src_rdy       out  NUM_SRC    word consumed when src_valid[i] & src_rdy[i]
//  tx_data       out  8          to MAC
//  tx_sop        out  1
//  tx_eop        out  1
//  tx_err        out  1          frame truncated/aborted
//  tx_wren       out  1          output word valid
//  tx_rdy        in   1          MAC accepts when tx_wren & tx_rdy at edge
//  grant         out  3          index of current owner
//  busy          out  1          state != IDLE
//  frames_sent   out  16         count of eop words accepted by MAC, wraps
//  frames_err    out  16         count of err words accepted by MAC, wraps
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, byte count 0. rstn low mid-frame aborts at once; no eop is emitted.
//  Output register: one word deep. Holds data until tx_rdy sampled high with tx_wren; never changes while tx_wren & ~tx_rdy.
//  Source-to-MAC latency: 1 cycle. src_rdy[grant] = (state==DATA) & (~tx_wren | tx_rdy); combinational from tx_rdy.
//  IDLE:
//   - Winner = first i with src_valid[i] & src_sop[i], searching from rr pointer upward, mod NUM_SRC.
//   - Registers grant, sets rr = winner+1 and goes to DATA; no word consumed in this cycle.
//   - Sources valid without sop get src_rdy=1; the word is dropped silently (stray bytes).
//  DATA (owner = grant):
//   - Forward word; byte count incremented per consumed word; tx_sop = src_sop.
//   - eop consumed -> IDLE, or PAD if padding applies.
//   - sop seen on a non-first word: word not consumed. Emit 0x00 with eop=1, err=1 -> IDLE; the new frame re-arbitrates.
//   - byte count reaches MAX_FRAME_LEN without eop: that word is emitted with eop=1, err=1 -> DROP.
//  DROP: src_rdy[grant]=1, words discarded through eop inclusive -> IDLE.
//  Non-owner src_rdy=0 in DATA/PAD/DROP.
//  Byte count: 11 bits, saturating, cleared in IDLE.
//  Minimum inter-frame gap: 1 cycle (IDLE). Simultaneous sop from all sources: strict rotation, rr pointer order.
//  frames_sent/frames_err update on the accepting edge.
// CONFIGURATION
//  TX_ARB_PAD_EN defined:
//   - eop consumed with byte count < MIN_FRAME_LEN: word forwarded with eop=0, state goes to PAD.
//   - PAD emits 0x00 (sop=0, err=0) under the same tx_rdy hold rule until count==MIN_FRAME_LEN; last pad byte eop=1 -> IDLE.
//  Not defined: PAD state absent, frames forwarded at source length, MIN_FRAME_LEN unused.
// TESTING
//  1. Reset, src0 sends 64-byte frame, tx_rdy=1 -> 64 writes, sop on byte 0, eop on byte 63, frames_sent=1, tx_err=0.
//  2. All 4 sources valid+sop with 10-byte frames -> grants in order 0,1,2,3,0, no interleaving, idle cycle between frames.
//  3. Toggle tx_rdy every 3 cycles during a frame -> tx_data/tx_sop/tx_eop stable while stalled, byte sequence intact.
//  4. Frame of 1600 bytes, MAX_FRAME_LEN=1514 -> 1514 writes, last with eop=1 err=1; remaining 86 drained; frames_err=1.
//  5. Stray sop mid-frame on owner after byte 5 -> 0x00 eop=1 err=1 written; new frame starts after 1 IDLE cycle.
//  6. TX_ARB_PAD_EN, 20-byte frame -> 60 writes, bytes 20..59 = 0x00, eop only on byte 59; without macro -> 20 writes.
//  7. rstn low mid-frame -> all outputs 0 immediately; after release, next frame starts clean from rr=0.

Source files
------------

// File: rtl/mac_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mac_tx_arbiter
// Description : Frame-granular round-robin arbiter sharing one MAC TX write
//               port among NUM_SRC packet sources. Never interleaves frames,
//               truncates over-length frames, and aborts frames on a stray sop.
//               Optional short-frame padding is enabled by TX_ARB_PAD_EN.
// Revision    : 1.0  initial release
// ============================================================================
module mac_tx_arbiter #(
    parameter int NUM_SRC       = 4,
    parameter int MAX_FRAME_LEN = 1514,
    parameter int MIN_FRAME_LEN = 60
) (
    input  logic                   tx_clk,
    input  logic                   rstn,
    input  logic [8*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]     src_sop,
    input  logic [NUM_SRC-1:0]     src_eop,
    input  logic [NUM_SRC-1:0]     src_valid,
    output logic [NUM_SRC-1:0]     src_rdy,
    output logic [7:0]             tx_data,
    output logic                   tx_sop,
    output logic                   tx_eop,
    output logic                   tx_err,
    output logic                   tx_wren,
    input  logic                   tx_rdy,
    output logic [2:0]             grant,
    output logic                   busy,
    output logic [15:0]            frames_sent,
    output logic [15:0]            frames_err
);

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_data = 2'd1;
    localparam logic [1:0]  c_st_pad  = 2'd2;
    localparam logic [1:0]  c_st_drop = 2'd3;
    localparam logic [10:0] c_max_len = 11'(MAX_FRAME_LEN);
`ifdef TX_ARB_PAD_EN
    localparam logic [10:0] c_min_len = 11'(MIN_FRAME_LEN);
`endif

    if (NUM_SRC < 2 || NUM_SRC > 8 || MAX_FRAME_LEN > 2047 || MIN_FRAME_LEN > MAX_FRAME_LEN) begin : g_bad_params
        $error("mac_tx_arbiter: illegal parameter set");
    end

    logic [1:0]         r_state, w_state_nxt;
    logic [2:0]         r_grant, w_grant_nxt;
    logic [2:0]         r_rr, w_rr_nxt;
    logic [10:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [7:0]         r_tx_data;
    logic               r_tx_sop, r_tx_eop, r_tx_err, r_tx_wren;
    logic [15:0]        r_frames_sent, r_frames_err;

    logic               w_out_free;
    logic               w_first;
    logic [NUM_SRC-1:0] w_req, w_rot, w_own;
    logic               w_found;
    logic [2:0]         w_off, w_win;
    logic [3:0]         w_sum;
    logic               w_g_valid, w_g_sop, w_g_eop;
    logic [7:0]         w_g_data;
    logic               w_own_rdy;
    logic               w_load;
    logic [7:0]         w_ld_data;
    logic               w_ld_sop, w_ld_eop, w_ld_err;

    // A word may enter the output register when it is empty or being drained.
    assign w_out_free = ~r_tx_wren | tx_rdy;
    assign w_first    = (r_cnt == 11'd0);
    assign w_cnt_inc  = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
    assign w_req      = src_valid & src_sop;

    // Rotate requests so bit 0 corresponds to the rr pointer, then take the lowest set bit.
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                if (r_rr == 3'(j)) w_rot[k] = w_req[(j + k) % NUM_SRC];
            end
        end
        w_found = |w_rot;
        w_off   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = 3'(i);
        end
        w_sum = {1'b0, r_rr} + {1'b0, w_off};
        w_win = (w_sum >= 4'(NUM_SRC)) ? 3'(w_sum - 4'(NUM_SRC)) : w_sum[2:0];
        w_rr_nxt = (w_win == 3'(NUM_SRC - 1)) ? 3'd0 : w_win + 3'd1;
    end

    always_comb begin
        w_own     = '0;
        w_g_valid = 1'b0;
        w_g_sop   = 1'b0;
        w_g_eop   = 1'b0;
        w_g_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant == 3'(i)) begin
                w_own[i]  = 1'b1;
                w_g_valid = src_valid[i];
                w_g_sop   = src_sop[i];
                w_g_eop   = src_eop[i];
                w_g_data  = src_data[8*i +: 8];
            end
        end
    end

    // A sop arriving after the first word is left on the source for re-arbitration.
    assign w_own_rdy = w_out_free & ~(w_g_sop & ~w_first);

    always_comb begin
        src_rdy = '0;
        case (r_state)
            c_st_idle: src_rdy = src_valid & ~src_sop;
            c_st_data: src_rdy = w_own & {NUM_SRC{w_own_rdy}};
            c_st_drop: src_rdy = w_own;
            default:   src_rdy = '0;
        endcase
        if (!rstn) src_rdy = '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_ld_data   = '0;
        w_ld_sop    = 1'b0;
        w_ld_eop    = 1'b0;
        w_ld_err    = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_cnt_nxt = '0;
                if (w_found) begin
                    w_grant_nxt = w_win;
                    w_state_nxt = c_st_data;
                end
            end
            c_st_data: begin
                if (w_g_valid && w_out_free) begin
                    w_load = 1'b1;
                    if (w_g_sop && !w_first) begin
                        w_ld_eop    = 1'b1;
                        w_ld_err    = 1'b1;
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_ld_data = w_g_data;
                        w_ld_sop  = w_g_sop;
                        w_cnt_nxt = w_cnt_inc;
                        if (w_g_eop) begin
                            w_ld_eop    = 1'b1;
                            w_state_nxt = c_st_idle;
`ifdef TX_ARB_PAD_EN
                            if (w_cnt_inc < c_min_len) begin
                                w_ld_eop    = 1'b0;
                                w_state_nxt = c_st_pad;
                            end
`endif
                        end else if (w_cnt_inc == c_max_len) begin
                            w_ld_eop    = 1'b1;
                            w_ld_err    = 1'b1;
                            w_state_nxt = c_st_drop;
                        end
                    end
                end
            end
`ifdef TX_ARB_PAD_EN
            c_st_pad: begin
                if (w_out_free) begin
                    w_load    = 1'b1;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_min_len) begin
                        w_ld_eop    = 1'b1;
                        w_state_nxt = c_st_idle;
                    end
                end
            end
`endif
            c_st_drop: begin
                if (w_g_valid && w_g_eop) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge tx_clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= c_st_idle;
            r_grant       <= '0;
            r_rr          <= '0;
            r_cnt         <= '0;
            r_tx_data     <= '0;
            r_tx_sop      <= 1'b0;
            r_tx_eop      <= 1'b0;
            r_tx_err      <= 1'b0;
            r_tx_wren     <= 1'b0;
            r_frames_sent <= '0;
            r_frames_err  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == c_st_idle && w_found) r_rr <= w_rr_nxt;
            if (w_load) begin
                r_tx_data <= w_ld_data;
                r_tx_sop  <= w_ld_sop;
                r_tx_eop  <= w_ld_eop;
                r_tx_err  <= w_ld_err;
                r_tx_wren <= 1'b1;
            end else if (tx_rdy) begin
                r_tx_wren <= 1'b0;
            end
            if (r_tx_wren && tx_rdy) begin
                if (r_tx_eop) r_frames_sent <= r_frames_sent + 16'd1;
                if (r_tx_err) r_frames_err  <= r_frames_err + 16'd1;
            end
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_sop      = r_tx_sop;
    assign tx_eop      = r_tx_eop;
    assign tx_err      = r_tx_err;
    assign tx_wren     = r_tx_wren;
    assign grant       = r_grant;
    assign busy        = (r_state != c_st_idle);
    assign frames_sent = r_frames_sent;
    assign frames_err  = r_frames_err;

endmodule
`default_nettype wire
